// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, frame/line strobes and
// pipelined hs/vs/de. Optional colour-bar source is enabled with TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int HACT  = 640,
  parameter int HFP   = 16,
  parameter int HSW   = 96,
  parameter int HBP   = 48,
  parameter int VACT  = 480,
  parameter int VFP   = 10,
  parameter int VSW   = 2,
  parameter int VBP   = 33,
  parameter bit HSPOL = 1'b0,
  parameter bit VSPOL = 1'b0,
  parameter int PIPE  = 2,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          active,
  output logic          fr,
  output logic          ln,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o
`ifdef TEST_PATTERN_EN
  ,
  output logic          red,
  output logic          grn,
  output logic          blu
`endif
);

  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;

  localparam logic [XW-1:0] H_ACT   = XW'(HACT);
  localparam logic [XW-1:0] H_SYNC0 = XW'(HACT + HFP);
  localparam logic [XW-1:0] H_SYNC1 = XW'(HACT + HFP + HSW);
  localparam logic [XW-1:0] H_LAST  = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] V_ACT   = YW'(VACT);
  localparam logic [YW-1:0] V_SYNC0 = YW'(VACT + VFP);
  localparam logic [YW-1:0] V_SYNC1 = YW'(VACT + VFP + VSW);
  localparam logic [YW-1:0] V_LAST  = YW'(VTOTAL - 1);

  logic [XW-1:0] h_reg, h_next;
  logic [YW-1:0] v_reg, v_next;
  logic          hs_reg, vs_reg;
  logic          act_next, fr_next, ln_next, hs_next, vs_next;

  always_comb begin
    h_next = h_reg + XW'(1);
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + YW'(1);
    end
  end

  // Decode from the next counter values so every registered output lines up with xpos/ypos.
  always_comb begin
    act_next = (h_next < H_ACT) && (v_next < V_ACT);
    fr_next  = (h_next == '0) && (v_next == '0);
    ln_next  = (h_next == H_ACT) && (v_next < V_ACT);
    hs_next  = ((h_next >= H_SYNC0) && (h_next < H_SYNC1)) ? HSPOL : !HSPOL;
    vs_next  = ((v_next >= V_SYNC0) && (v_next < V_SYNC1)) ? VSPOL : !VSPOL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg  <= H_LAST;
      v_reg  <= V_LAST;
      active <= 1'b0;
      fr     <= 1'b0;
      ln     <= 1'b0;
      hs_reg <= !HSPOL;
      vs_reg <= !VSPOL;
    end else if (ce) begin
      h_reg  <= h_next;
      v_reg  <= v_next;
      active <= act_next;
      fr     <= fr_next;
      ln     <= ln_next;
      hs_reg <= hs_next;
      vs_reg <= vs_next;
    end
  end

  assign xpos = h_reg;
  assign ypos = v_reg;

`ifdef TEST_PATTERN_EN
  localparam int DW = 6;
  localparam logic [DW-1:0] IDLE = {!HSPOL, !VSPOL, 4'b0000};

  logic [2:0] bar_next;
  logic [2:0] rgb_reg;

  // Bar k starts at ceil(k*HACT/8); the last threshold passed gives the bar index.
  always_comb begin
    bar_next = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_next >= XW'((k * HACT + 7) / 8)) bar_next = 3'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_reg <= 3'b000;
    else if (ce) rgb_reg <= ~bar_next;
  end

  logic [DW-1:0] aligned;
  logic [DW-1:0] delayed;
  assign aligned = {hs_reg, vs_reg, active, rgb_reg};
`else
  localparam int DW = 3;
  localparam logic [DW-1:0] IDLE = {!HSPOL, !VSPOL, 1'b0};

  logic [DW-1:0] aligned;
  logic [DW-1:0] delayed;
  assign aligned = {hs_reg, vs_reg, active};
`endif

  generate
    if (PIPE == 0) begin : g_nopipe
      assign delayed = aligned;
    end else begin : g_pipe
      for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
        logic [DW-1:0] q_reg;
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (rst) q_reg <= IDLE;
            else if (ce) q_reg <= aligned;
          end
        end else begin : g_rest
          always_ff @(posedge clk) begin
            if (rst) q_reg <= IDLE;
            else if (ce) q_reg <= g_stage[gi-1].q_reg;
          end
        end
      end
      assign delayed = g_stage[PIPE-1].q_reg;
    end
  endgenerate

  assign hs_o = delayed[DW-1];
  assign vs_o = delayed[DW-2];
  assign de_o = delayed[DW-3];

`ifdef TEST_PATTERN_EN
  assign red = delayed[2] & de_o;
  assign grn = delayed[1] & de_o;
  assign blu = delayed[0] & de_o;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small 14x8 mode, one instance with PIPE=3 and
// active-low sync, one with PIPE=0 and active-high sync, run side by side.
module tb_vga_timing_gen;

  localparam int HACT = 8, HFP = 2, HSW = 3, HBP = 1;
  localparam int VACT = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HACT + HFP + HSW + HBP;
  localparam int VT = VACT + VFP + VSW + VBP;
  localparam int PIPE_A = 3;
`ifdef TEST_PATTERN_EN
  localparam int OW = 58;
`else
  localparam int OW = 52;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  logic [9:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic active_a, fr_a, ln_a, hs_a, vs_a, de_a;
  logic active_b, fr_b, ln_b, hs_b, vs_b, de_b;
`ifdef TEST_PATTERN_EN
  logic red_a, grn_a, blu_a, red_b, grn_b, blu_b;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int mx, my;
  logic e_act, e_fr, e_ln;
  logic [5:0] q_a[$];
  logic [5:0] out_a, out_b;
  logic [OW-1:0] exp_vec;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .HSPOL(1'b0), .VSPOL(1'b0), .PIPE(PIPE_A), .XW(10), .YW(10)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce),
    .xpos(xpos_a), .ypos(ypos_a), .active(active_a), .fr(fr_a), .ln(ln_a),
    .hs_o(hs_a), .vs_o(vs_a), .de_o(de_a)
`ifdef TEST_PATTERN_EN
    , .red(red_a), .grn(grn_a), .blu(blu_a)
`endif
  );

  vga_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .HSPOL(1'b1), .VSPOL(1'b1), .PIPE(0), .XW(10), .YW(10)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce),
    .xpos(xpos_b), .ypos(ypos_b), .active(active_b), .fr(fr_b), .ln(ln_b),
    .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b)
`ifdef TEST_PATTERN_EN
    , .red(red_b), .grn(grn_b), .blu(blu_b)
`endif
  );

  function automatic logic [OW-1:0] obs_vec();
    obs_vec = {xpos_a, ypos_a, active_a, fr_a, ln_a, hs_a, vs_a, de_a,
               xpos_b, ypos_b, active_b, fr_b, ln_b, hs_b, vs_b, de_b
`ifdef TEST_PATTERN_EN
               , red_a, grn_a, blu_a, red_b, grn_b, blu_b
`endif
              };
  endfunction

  task automatic model_reset();
    mx = HT - 1;
    my = VT - 1;
    e_act = 1'b0;
    e_fr  = 1'b0;
    e_ln  = 1'b0;
    q_a.delete();
    repeat (PIPE_A) q_a.push_back(6'b110000);
    out_a = 6'b110000;
    out_b = 6'b000000;
  endtask

  // One clk edge: drive ce, then advance the model and the delay scoreboard.
  task automatic advance(input logic ce_v);
    logic hs_as, vs_as;
    logic [2:0] rgb;
    ce = ce_v;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (ce_v) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      e_act = (mx < HACT) && (my < VACT);
      e_fr  = (mx == 0) && (my == 0);
      e_ln  = (mx == HACT) && (my < VACT);
      hs_as = (mx >= HACT + HFP) && (mx < HACT + HFP + HSW);
      vs_as = (my >= VACT + VFP) && (my < VACT + VFP + VSW);
      rgb   = e_act ? ~(3'((mx * 8) / HACT)) : 3'b000;
      q_a.push_back({~hs_as, ~vs_as, e_act, rgb});
      out_a = q_a.pop_front();
      out_b = {hs_as, vs_as, e_act, rgb};
    end
    exp_vec = {10'(mx), 10'(my), e_act, e_fr, e_ln, out_a[5:3],
               10'(mx), 10'(my), e_act, e_fr, e_ln, out_b[5:3]
`ifdef TEST_PATTERN_EN
               , out_a[2:0], out_b[2:0]
`endif
              };
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance(i[0]);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset i=%0d got %h want %h", i, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (xpos_a !== 10'd13 || ypos_a !== 10'd7 || hs_b !== 1'b0 || hs_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d hs_a=%b hs_b=%b want x=13 y=7 hs_a=1 hs_b=0",
               xpos_a, ypos_a, hs_a, hs_b);
    end
  endtask

  task automatic test_frame();
    int fr_idx[$];
    int act_cnt = 0;
    int first_de = -1;
    rst = 1'b0;
    for (int c = 0; c < 3 * HT * VT; c++) begin
      advance(1'b1);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL frame c=%0d got %h want %h", c, obs_vec(), exp_vec);
      end
      if (fr_a) fr_idx.push_back(c);
      if (active_a && c < HT * VT) act_cnt++;
      if (de_a && first_de < 0) first_de = c;
    end
    checks++;
    if (fr_idx.size() != 3 || fr_idx[0] != 0 || fr_idx[1] != 112 || fr_idx[2] != 224) begin
      errors++;
      $display("FAIL fr_positions got count=%0d first=%0d want count=3 at 0,112,224",
               fr_idx.size(), (fr_idx.size() > 0) ? fr_idx[0] : -1);
    end
    checks++;
    if (act_cnt != 32) begin
      errors++;
      $display("FAIL active_count got %0d want 32", act_cnt);
    end
    checks++;
    if (first_de != PIPE_A) begin
      errors++;
      $display("FAIL first_de got %0d want %0d", first_de, PIPE_A);
    end
  endtask

  task automatic test_ce_throttle();
    int rise[$];
    logic prev_fr = 1'b0;
    rst = 1'b1;
    advance(1'b1);
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      advance((c % 4) == 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL ce_throttle c=%0d got %h want %h", c, obs_vec(), exp_vec);
      end
      if (fr_a && !prev_fr) rise.push_back(c);
      prev_fr = fr_a;
    end
    checks++;
    if (rise.size() < 3 || rise[1] - rise[0] != 448 || rise[2] - rise[1] != 448) begin
      errors++;
      $display("FAIL frame_period got rises=%0d period=%0d want 448",
               rise.size(), (rise.size() > 1) ? rise[1] - rise[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    rst = 1'b1;
    advance(1'b1);
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      advance(1'b1);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL mid_run c=%0d got %h want %h", c, obs_vec(), exp_vec);
      end
      if (xpos_a == 10'd5 && ypos_a == 10'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_5_2 got timeout want position (5,2)");
    end
    rst = 1'b1;
    advance(1'b1);
    checks++;
    if (obs_vec() !== exp_vec || xpos_a !== 10'd13 || ypos_a !== 10'd7 || active_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", obs_vec(), exp_vec);
    end
    advance(1'b0);
    checks++;
    if (obs_vec() !== exp_vec) begin
      errors++;
      $display("FAIL rst_over_ce got %h want %h", obs_vec(), exp_vec);
    end
    rst = 1'b0;
    advance(1'b1);
    checks++;
    if (xpos_a !== 10'd0 || ypos_a !== 10'd0 || fr_a !== 1'b1 || obs_vec() !== exp_vec) begin
      errors++;
      $display("FAIL restart got x=%0d y=%0d fr=%b want x=0 y=0 fr=1", xpos_a, ypos_a, fr_a);
    end
    for (int c = 0; c < 2 * HT * VT; c++) begin
      advance(($urandom_range(0, 2)) != 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL random_ce c=%0d got %h want %h", c, obs_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_ce_throttle();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
